// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: job configuration, serial stream and status signals of the pattern scanner
interface pattern_scan_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int NBW    = 16,
  parameter int CNTW   = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [NBW-1:0]    cfg_num_bits;
  logic              abort;
  logic              d;
  logic              d_valid;
  logic              Q;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;
  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_num_bits, abort, d, d_valid,
    input  cfg_ready, Q, match_count, busy, done
  );
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_num_bits, abort, d, d_valid,
    output cfg_ready, Q, match_count, busy, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: runs one configurable serial pattern-detection job at a time
module pattern_scan_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int NBW    = 16,
  parameter int CNTW   = 8
) (
  input logic clk,
  input logic rst,
  pattern_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [MAXLEN-1:0] pattern, hist, hist_n, mask;
  logic [LENW-1:0] len, len_c, fill, fill_n;
  logic [LENW:0] fill_inc;
  logic [NBW-1:0] num_bits, bits;
  logic overlap, take, step, hit, last;
  assign take = state == IDLE && bus.cfg_valid && bus.cfg_ready;
  assign step = state == SCAN && !bus.abort && bus.d_valid && num_bits != '0;
  assign last = step && bits + NBW'(1) == num_bits;
  assign len_c = bus.cfg_len == '0 ? LENW'(1) : bus.cfg_len > LENW'(MAXLEN) ? LENW'(MAXLEN) : bus.cfg_len;
  assign hist_n = {hist[MAXLEN-2:0], bus.d};
  assign mask = ~({MAXLEN{1'b1}} << len);
  assign fill_inc = {1'b0, fill} + (LENW+1)'(1);
  assign hit = step && fill_inc >= {1'b0, len} && ((hist_n ^ pattern) & mask) == '0;
  always_comb begin
    state_n = state;
    fill_n = fill;
    // non-overlapping mode restarts the fill so the next match needs len fresh bits
    fill_n = hit && !overlap ? '0 : fill_inc > (LENW+1)'(MAXLEN) ? LENW'(MAXLEN) : fill_inc[LENW-1:0];
    state_n = state == IDLE ? (take ? SCAN : IDLE) :
              state == DONE ? IDLE :
              bus.abort ? IDLE :
              (num_bits == '0 || last) ? DONE : SCAN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pattern <= '0;
      len <= '0;
      overlap <= 1'b0;
      num_bits <= '0;
      hist <= '0;
      fill <= '0;
      bits <= '0;
      bus.cfg_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Q <= 1'b0;
      bus.match_count <= '0;
    end else begin
      state <= state_n;
      bus.cfg_ready <= state_n == IDLE;
      bus.busy <= state_n == SCAN;
      bus.done <= state_n == DONE;
      bus.Q <= hit;
      if (take) begin
        pattern <= bus.cfg_pattern;
        len <= len_c;
        overlap <= bus.cfg_overlap;
        num_bits <= bus.cfg_num_bits;
        hist <= '0;
        fill <= '0;
        bits <= '0;
        bus.match_count <= '0;
      end else if (step) begin
        hist <= hist_n;
        fill <= fill_n;
        bits <= bits + NBW'(1);
        if (hit && bus.match_count != '1) bus.match_count <= bus.match_count + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and randomized jobs checked against a stream-level reference model
module tb_pattern_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pattern_scan_ctrl_if #(.MAXLEN(8), .LENW(4), .NBW(16), .CNTW(8)) bus();
  pattern_scan_ctrl #(.MAXLEN(8), .LENW(4), .NBW(16), .CNTW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0, mismatched = 0;
  int ph, m_len, m_nb, m_n, since, e_cnt;
  int m_pat;
  bit m_ov;
  bit hq[$];
  bit stim[$];
  int q_at[$];
  int done_at, last_ticks;
  bit done_with_q;
  logic e_q, e_done, e_busy, e_ready;

  task automatic model_reset;
    ph = 0; e_cnt = 0; m_n = 0; since = 0; hq.delete();
    e_q = 0; e_done = 0; e_busy = 0; e_ready = 0;
  endtask

  // ph: 0 waiting for a job, 1 consuming stream, 2 reporting completion
  task automatic tick(input logic cv, input logic ab, input logic dd, input logic dv);
    bit nq;
    int v;
    nq = 0;
    bus.cfg_valid = cv; bus.abort = ab; bus.d = dd; bus.d_valid = dv;
    @(posedge clk);
    if (ph == 0) begin
      if (cv && e_ready) begin
        m_pat = int'(bus.cfg_pattern);
        m_len = bus.cfg_len == 0 ? 1 : (bus.cfg_len > 8 ? 8 : int'(bus.cfg_len));
        m_ov = bus.cfg_overlap; m_nb = int'(bus.cfg_num_bits);
        m_n = 0; since = 0; hq.delete(); e_cnt = 0; ph = 1;
      end
    end else if (ph == 2) ph = 0;
    else if (ab) ph = 0;
    else if (m_nb == 0) ph = 2;
    else if (dv) begin
      hq.push_back(dd); m_n++; since++;
      if (since >= m_len) begin
        v = 0;
        for (int i = hq.size() - m_len; i < hq.size(); i++) v = (v << 1) | int'(hq[i]);
        if (v == (m_pat & ((1 << m_len) - 1))) begin
          nq = 1;
          if (e_cnt < 255) e_cnt++;
          if (!m_ov) since = 0;
        end
      end
      if (m_n == m_nb) ph = 2;
    end
    e_q = nq; e_done = ph == 2; e_busy = ph == 1; e_ready = ph == 0;
    @(negedge clk);
  endtask

  task automatic run_job(input logic [7:0] pat, input logic [3:0] len, input bit ov, input int nb,
                         input int vmode, input int abort_at, input bit noise);
    int t;
    logic dv, ab, cv;
    t = 0;
    q_at.delete(); done_at = -1; done_with_q = 0;
    bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ov; bus.cfg_num_bits = 16'(nb);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL accept_busy got %b exp 1", bus.busy); end
    while (ph != 0) begin
      if (t > 8 * nb + 20) begin
        compared++; mismatched++;
        $display("FAIL job_timeout after %0d cycles, exp completion", t);
        break;
      end
      dv = vmode == 0 ? 1'b1 : vmode == 1 ? (t % 2 == 0) : ($urandom_range(0, 3) != 0);
      ab = abort_at >= 0 && m_n == abort_at;
      cv = noise && ($urandom_range(0, 1) == 1);
      if (noise) begin
        bus.cfg_pattern = 8'($urandom); bus.cfg_len = 4'($urandom); bus.cfg_num_bits = 16'($urandom_range(0, 5));
      end
      tick(cv, ab, stim[m_n % stim.size()], dv);
      t++;
      compared++; if (bus.Q !== e_q) begin mismatched++; $display("FAIL q t=%0d got %b exp %b", t, bus.Q, e_q); end
      compared++; if (bus.done !== e_done) begin mismatched++; $display("FAIL done t=%0d got %b exp %b", t, bus.done, e_done); end
      compared++; if (bus.busy !== e_busy) begin mismatched++; $display("FAIL busy t=%0d got %b exp %b", t, bus.busy, e_busy); end
      compared++; if (bus.cfg_ready !== e_ready) begin mismatched++; $display("FAIL ready t=%0d got %b exp %b", t, bus.cfg_ready, e_ready); end
      compared++; if (bus.match_count !== 8'(e_cnt)) begin mismatched++; $display("FAIL count t=%0d got %0d exp %0d", t, bus.match_count, e_cnt); end
      if (bus.Q === 1'b1) q_at.push_back(m_n);
      if (bus.done === 1'b1) begin done_at = t; done_with_q = bus.Q; end
    end
    last_ticks = t + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; model_reset();
    @(negedge clk); @(negedge clk);
    compared++;
    if ({bus.cfg_ready, bus.Q, bus.busy, bus.done, bus.match_count} !== 12'h0) begin
      mismatched++;
      $display("FAIL reset_outputs got rdy=%b q=%b busy=%b done=%b cnt=%0d exp all 0", bus.cfg_ready, bus.Q, bus.busy, bus.done, bus.match_count);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", bus.cfg_ready, bus.busy);
    end
  endtask

  task automatic test_overlap;
    stim = '{1, 0, 1, 1, 0, 1, 1};
    run_job(8'b1011, 4'd4, 1'b1, 7, 0, -1, 1'b0);
    compared++;
    if (q_at.size() != 2 || q_at[0] != 4 || q_at[1] != 7) begin
      mismatched++; $display("FAIL ovl_q_pos got %0d pulses exp pulses after bits 4,7", q_at.size());
    end
    compared++;
    if (bus.match_count !== 8'd2) begin mismatched++; $display("FAIL ovl_count got %0d exp 2", bus.match_count); end
    compared++;
    if (done_at != 7 || !done_with_q) begin mismatched++; $display("FAIL ovl_done got at=%0d withq=%b exp at=7 withq=1", done_at, done_with_q); end
  endtask

  task automatic test_nonoverlap;
    stim = '{1, 0, 1, 1, 0, 1, 1};
    run_job(8'b1011, 4'd4, 1'b0, 7, 0, -1, 1'b0);
    compared++;
    if (q_at.size() != 1 || q_at[0] != 4) begin mismatched++; $display("FAIL novl_q_pos got %0d pulses exp one after bit 4", q_at.size()); end
    compared++;
    if (bus.match_count !== 8'd1 || done_at != 7) begin
      mismatched++; $display("FAIL novl_count got cnt=%0d done_at=%0d exp cnt=1 done_at=7", bus.match_count, done_at);
    end
  endtask

  task automatic test_saturate;
    stim = '{1};
    run_job(8'h01, 4'd1, 1'b1, 300, 0, -1, 1'b0);
    compared++;
    if (bus.match_count !== 8'd255 || done_at != 300 || q_at.size() != 300) begin
      mismatched++; $display("FAIL sat got cnt=%0d done_at=%0d pulses=%0d exp 255/300/300", bus.match_count, done_at, q_at.size());
    end
  endtask

  task automatic test_gapped;
    stim = '{1, 0, 1, 1, 0, 1, 1};
    run_job(8'b1011, 4'd4, 1'b1, 7, 1, -1, 1'b0);
    compared++;
    if (q_at.size() != 2 || q_at[0] != 4 || q_at[1] != 7 || done_at != 13 || bus.match_count !== 8'd2) begin
      mismatched++; $display("FAIL gap got pulses=%0d done_at=%0d cnt=%0d exp 2/13/2", q_at.size(), done_at, bus.match_count);
    end
  endtask

  task automatic test_abort;
    stim = '{1, 0, 1, 1, 0, 1, 1};
    run_job(8'b1011, 4'd4, 1'b1, 7, 0, 3, 1'b0);
    compared++;
    if (q_at.size() != 0 || done_at != -1 || bus.match_count !== 8'd0) begin
      mismatched++; $display("FAIL abort got pulses=%0d done_at=%0d cnt=%0d exp 0/-1/0", q_at.size(), done_at, bus.match_count);
    end
    compared++;
    if (last_ticks != 5 || bus.cfg_ready !== 1'b1) begin
      mismatched++; $display("FAIL abort_idle got ticks=%0d rdy=%b exp 5/1", last_ticks, bus.cfg_ready);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL abort_in_idle got rdy=%b busy=%b exp 1/0", bus.cfg_ready, bus.busy);
    end
  endtask

  task automatic test_len_clamp;
    stim = '{1, 0, 1};
    run_job(8'h01, 4'd0, 1'b1, 3, 0, -1, 1'b0);
    compared++;
    if (q_at.size() != 2 || q_at[0] != 1 || q_at[1] != 3) begin mismatched++; $display("FAIL len0 got %0d pulses exp after bits 1,3", q_at.size()); end
    stim = '{1, 0, 1, 1, 0, 0, 1, 1};
    run_job(8'b10110011, 4'd12, 1'b1, 8, 0, -1, 1'b0);
    compared++;
    if (q_at.size() != 1 || q_at[0] != 8 || bus.match_count !== 8'd1) begin
      mismatched++; $display("FAIL len12 got pulses=%0d cnt=%0d exp 1 pulse after bit 8, cnt 1", q_at.size(), bus.match_count);
    end
  endtask

  task automatic test_zero_bits;
    stim = '{1};
    run_job(8'h01, 4'd1, 1'b1, 0, 0, -1, 1'b0);
    compared++;
    if (done_at != 1 || q_at.size() != 0 || bus.match_count !== 8'd0 || last_ticks != 3) begin
      mismatched++; $display("FAIL zero_bits got done_at=%0d pulses=%0d cnt=%0d ticks=%0d exp 1/0/0/3", done_at, q_at.size(), bus.match_count, last_ticks);
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 3; j++) begin
      int nb;
      nb = $urandom_range(1, 10);
      stim.delete();
      for (int i = 0; i < nb; i++) stim.push_back(1'($urandom_range(0, 1)));
      run_job(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), nb, 0, -1, 1'b0);
      compared++;
      if (last_ticks != nb + 2) begin mismatched++; $display("FAIL b2b_turnaround got %0d exp %0d", last_ticks, nb + 2); end
    end
  endtask

  task automatic test_reset_mid;
    stim = '{1};
    bus.cfg_pattern = 8'h01; bus.cfg_len = 4'd1; bus.cfg_overlap = 1'b1; bus.cfg_num_bits = 16'd20;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus.cfg_ready, bus.Q, bus.busy, bus.done, bus.match_count} !== 12'h0) begin
      mismatched++;
      $display("FAIL rst_mid got rdy=%b q=%b busy=%b done=%b cnt=%0d exp all 0", bus.cfg_ready, bus.Q, bus.busy, bus.done, bus.match_count);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    compared++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.match_count !== 8'd0) begin
      mismatched++; $display("FAIL rst_mid_release got rdy=%b busy=%b cnt=%0d exp 1/0/0", bus.cfg_ready, bus.busy, bus.match_count);
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 40; j++) begin
      int nb, ab_at;
      logic [3:0] len;
      nb = $urandom_range(0, 40);
      len = $urandom_range(0, 9) == 0 ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      ab_at = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, nb)) : -1;
      stim.delete();
      for (int i = 0; i <= nb; i++) stim.push_back(1'($urandom_range(0, 1)));
      run_job(8'($urandom), len, 1'($urandom_range(0, 1)), nb, 2, ab_at, 1'b1);
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        compared++;
        if (bus.cfg_ready !== 1'b1 || bus.match_count !== 8'(e_cnt)) begin
          mismatched++; $display("FAIL rand_idle got rdy=%b cnt=%0d exp 1/%0d", bus.cfg_ready, bus.match_count, e_cnt);
        end
      end
    end
  endtask

  initial begin
    bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_num_bits = 0; bus.abort = 0; bus.d = 0; bus.d_valid = 0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_saturate();
    test_gapped();
    test_abort();
    test_len_clamp();
    test_zero_bits();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Programmable controller that runs one serial pattern-detection job at a time. The job is configured through a valid/ready handshake: pattern, length, overlap mode and bit budget. The block consumes a qualified serial bit stream, pulses a match output and counts matches, then signals completion. It sits in front of the serial-detection datapath, sequencing when bits are examined and what pattern is matched, so one detector can be reconfigured between jobs without resynthesis.

## Interface
- MAXLEN, 8, maximum pattern length in bits (2..15)
- LENW, 4, width of cfg_len
- NBW, 16, width of cfg_num_bits (job bit budget)
- CNTW, 8, width of match_count
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs
- cfg_valid  input  1  job request
- cfg_ready  output  1  high only in IDLE
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first bit expected, bit [0] the last
- cfg_len  input  LENW  pattern length
- cfg_overlap  input  1  1 = overlapping matches counted, 0 = non-overlapping
- cfg_num_bits  input  NBW  number of stream bits the job consumes
- abort  input  1  cancel the running job
- d  input  1  serial data bit
- d_valid  input  1  d is sampled this cycle
- Q  output  1  one-cycle match pulse
- match_count  output  CNTW  matches in the current/last job, saturating
- busy  output  1  high in SCAN
- done  output  1  one-cycle job-complete pulse

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid & cfg_ready: latch all cfg_* fields; clear history, fill counter, bit counter and match_count; go to SCAN.
- cfg_len clamping at latch time: 0 becomes 1; values above MAXLEN become MAXLEN.
- cfg_num_bits=0: go to SCAN, then DONE on the next cycle with match_count=0.
- SCAN, on each cycle with d_valid=1:
  - hist <= {hist[MAXLEN-2:0], d}.
  - fill <= min(fill+1, MAXLEN).
  - bits <= bits+1.
  - Match when (fill+1) >= len and the low len bits of the new hist equal cfg_pattern[len-1:0].
- On a match:
  - Q=1 next cycle.
  - match_count increments, saturating at 2^CNTW-1.
  - If overlap=0, fill is reset to 0, so the next match needs len fresh bits.
- d_valid=0: no state change; Q=0.
- When the sampled bit makes bits equal to cfg_num_bits, go to DONE.
- Bits arriving after the last budgeted bit are ignored (state is no longer SCAN).
- DONE: done=1 for one cycle, then IDLE. match_count holds until the next job is accepted.
- abort in SCAN: go to IDLE next cycle with no done pulse and no Q for that cycle's bit. match_count holds. abort takes priority over d_valid.
- abort in IDLE or DONE: ignored.
- cfg_valid outside IDLE: ignored; no cfg_ready.
- Reset values: cfg_ready=0 during rst (becomes 1 in IDLE after release), Q=0, match_count=0, busy=0, done=0, state=IDLE, hist=0.
- Reset mid-job: job lost. After release the block is in IDLE with count 0.

## Timing
- All outputs are registered.
- Config accepted on edge N: busy=1 from N+1, and the first bit can be sampled at edge N+1.
- Bit sampled at edge K completing a match: Q=1 during cycle K+1 (latency 1).
- Last budgeted bit sampled at edge K: state=DONE and done=1 in cycle K+1, with any Q for that bit coinciding. Then cfg_ready=1 from K+2.
- A new job can be accepted at the earliest edge K+2. Minimum job turnaround is cfg_num_bits+2 cycles with continuous d_valid.

## Test plan
- Pattern 1011, len 4, overlap=1, num_bits 7, stream 1,0,1,1,0,1,1 with continuous d_valid -> Q pulses after bits 4 and 7; match_count=2; done coincides with the second Q.
- Same stream with overlap=0 -> single Q after bit 4; match_count=1; done after bit 7.
- Pattern 1, len 1, num_bits 300, all ones, CNTW=8 -> match_count saturates at 255; done after bit 300.
- d_valid toggled 1,0,1,0… around the stream from scenario 1 -> same Q pattern, with each Q one cycle after its completing valid bit; idle cycles produce no Q.
- Abort after bit 3 of scenario 1 -> no Q, no done; IDLE and cfg_ready=1 next cycle; match_count=0.
- Edge cases:
  - rst asserted mid-job -> all outputs 0 immediately.
  - cfg_len=0 -> treated as len 1.
  - cfg_len=12 with MAXLEN=8 -> treated as len 8.
  - cfg_num_bits=0 -> done two cycles after accept, count 0.
